// File: rtl/game_input_conditioner.sv
// -----------------------------------------------------------------------------
// game_input_conditioner
//
// Purpose:
//   Conditions raw push-button pads for the Tetris game controller. Each
//   channel is synchronized (2 flops), debounced into a stable level, and
//   turned into a one-cycle press pulse. Selected channels additionally
//   produce auto-repeat pulses while the button is held.
//
// Ports:
//   clk_i           - 1 MHz clock
//   reset_n_i       - asynchronous assert, synchronous release, active-low reset
//   btn_raw_i       - raw button pads, active-high (bit0 left, 1 right,
//                     2 rotate, 3 start)
//   btn_level_o     - debounced level
//   btn_press_o     - one-cycle pulse on each debounced rising edge
//   btn_act_o       - press pulse OR auto-repeat pulse
//   dbg_rpt_state_o - repeat FSM state, 2 bits per channel (0 = eIdle,
//                     1 = eDelay, 2 = eRepeat); zero for channels without
//                     a repeat FSM
//
// Build option:
//   GAME_INPUT_AUTOREPEAT_EN - when defined, repeat FSMs are built for the
//   channels in repeat_mask_p. When undefined no repeat logic exists and
//   btn_act_o equals btn_press_o on every channel.
//
// Handshake: all pulse outputs are single-cycle strobes that act as a
// "valid" with no ready; a consumer must sample them on the cycle they are
// high, they are never held or stretched.
// -----------------------------------------------------------------------------
module game_input_conditioner #(
   parameter int                       num_buttons_p     = 4,
   parameter int                       debounce_cycles_p = 5000,
   parameter int                       repeat_delay_p    = 300000,
   parameter int                       repeat_period_p   = 100000,
   parameter logic [num_buttons_p-1:0] repeat_mask_p     = 4'b0011
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic [num_buttons_p-1:0]   btn_raw_i,
   output logic [num_buttons_p-1:0]   btn_level_o,
   output logic [num_buttons_p-1:0]   btn_press_o,
   output logic [num_buttons_p-1:0]   btn_act_o,
   output logic [2*num_buttons_p-1:0] dbg_rpt_state_o
);

   localparam int db_w_lp = (debounce_cycles_p > 1) ? $clog2(debounce_cycles_p) : 1;
   localparam logic [db_w_lp-1:0] db_tc_lp = db_w_lp'(debounce_cycles_p - 1);

`ifdef GAME_INPUT_AUTOREPEAT_EN
   localparam int rpt_max_lp = (repeat_delay_p > repeat_period_p) ? repeat_delay_p
                                                                  : repeat_period_p;
   localparam int rpt_w_lp   = (rpt_max_lp > 1) ? $clog2(rpt_max_lp) : 1;
   localparam logic [rpt_w_lp-1:0] delay_tc_lp  = rpt_w_lp'(repeat_delay_p - 1);
   localparam logic [rpt_w_lp-1:0] period_tc_lp = rpt_w_lp'(repeat_period_p - 1);

   typedef enum logic [1:0] {
      eIdle   = 2'd0,
      eDelay  = 2'd1,
      eRepeat = 2'd2
   } rpt_state_e;
`endif

   for (genvar i = 0; i < num_buttons_p; i++) begin : g_ch
      logic               meta_q, sync_q;
      logic               lvl_q, lvl_d;
      logic [db_w_lp-1:0] db_cnt_q, db_cnt_d;
      logic               level_q, press_q, act_q;
      logic               rise;
      logic               rpt_pulse;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            lvl_q    <= 1'b0;
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
            act_q    <= 1'b0;
         end else begin
            meta_q   <= btn_raw_i[i];
            sync_q   <= meta_q;
            lvl_q    <= lvl_d;
            db_cnt_q <= db_cnt_d;
            level_q  <= lvl_q;
            press_q  <= rise;
            act_q    <= rise | rpt_pulse;
         end
      end

      // Counter only advances while the synchronized input disagrees with
      // the stable level; any agreement wipes the accumulated count.
      always_comb begin
         lvl_d    = lvl_q;
         db_cnt_d = '0;
         if (sync_q != lvl_q) begin
            if (db_cnt_q == db_tc_lp) begin
               lvl_d = ~lvl_q;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
      end

      // level_q is lvl delayed by one cycle, so this marks the first cycle
      // of a new high level; registering it lines the press pulse up with
      // the first high cycle of btn_level_o.
      assign rise = lvl_q & ~level_q;

      assign btn_level_o[i] = level_q;
      assign btn_press_o[i] = press_q;
      assign btn_act_o[i]   = act_q;

`ifdef GAME_INPUT_AUTOREPEAT_EN
      if (repeat_mask_p[i]) begin : g_rpt
         rpt_state_e          state_q, state_d;
         logic [rpt_w_lp-1:0] cnt_q, cnt_d;
         logic                fall;

         // Falls on the very edge at which lvl drops, so it can veto a
         // terminal count landing on that same edge.
         assign fall = lvl_q & ~lvl_d;

         always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
               state_q <= eIdle;
               cnt_q   <= '0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
            end
         end

         always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            rpt_pulse = 1'b0;
            if (fall) begin
               state_d = eIdle;
               cnt_d   = '0;
            end else begin
               case (state_q)
                  eIdle: begin
                     cnt_d = '0;
                     if (rise) state_d = eDelay;
                  end
                  eDelay: begin
                     if (cnt_q == delay_tc_lp) begin
                        rpt_pulse = 1'b1;
                        state_d   = eRepeat;
                        cnt_d     = '0;
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
                  eRepeat: begin
                     if (cnt_q == period_tc_lp) begin
                        rpt_pulse = 1'b1;
                        cnt_d     = '0;
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
                  default: begin
                     state_d = eIdle;
                     cnt_d   = '0;
                  end
               endcase
            end
         end

         assign dbg_rpt_state_o[2*i +: 2] = state_q;
      end else begin : g_no_rpt
         assign rpt_pulse                 = 1'b0;
         assign dbg_rpt_state_o[2*i +: 2] = 2'b00;
      end
`else
      assign rpt_pulse                 = 1'b0;
      assign dbg_rpt_state_o[2*i +: 2] = 2'b00;
`endif
   end

endmodule
